br_next_pc: RTL and testbench
=============================

BR_NEXT_PC -- requirements
Module: br_next_pc

Interface
REQ-001 SHALL have parameter BHT_ENTRIES, default 64: number of 2-bit counters; power of two.
REQ-002 SHALL have parameter RESET_PC, default 16'h0000: fetch PC after reset.
REQ-003 SHALL have port iClk, input, 1: sole clock; all state updates on its rising edge.
REQ-004 SHALL have port iRstN, input, 1: reset, synchronous and active-low.
REQ-005 SHALL have port iStall, input, 1: fetch stall; holds the PC unless a redirect occurs.
REQ-006 SHALL have ports iBtbHit (input, 1) and iBtbAddr (input, lc3b_word): BTB lookup result for the current oPc.
REQ-007 SHALL have ports iResValid (input, 1), iResPc (input, lc3b_word), iResTaken (input, 1) and iResTarget (input, lc3b_word): actual outcome of one resolved branch.
REQ-008 SHALL have ports iResPredTaken (input, 1) and iResPredTarget (input, lc3b_word): prediction carried down the pipe with that branch.
REQ-009 SHALL have port oPc, output, lc3b_word: current fetch PC; drives the BTB read PC and the I-fetch.
REQ-010 SHALL have ports oPredTaken (output, 1) and oPredTarget (output, lc3b_word): prediction for oPc.
REQ-011 SHALL have port oFlush, output, 1: mispredict flush pulse.
REQ-012 SHALL have ports oBtbWe (output, 1), oBtbWPc (output, lc3b_word) and oBtbWAddr (output, lc3b_word): BTB update request.
REQ-013 SHALL have ports oBrCount and oMissCount, output, 16 each: statistics counters.

Function
REQ-014 SHALL index the BHT with idx(pc) = pc[log2(BHT_ENTRIES):1], ignoring bit 0.
REQ-015 SHALL drive oPredTaken = iBtbHit & BHT[idx(oPc)][1] and oPredTarget = iBtbAddr, both combinational.
REQ-016 SHALL compute mispredict = iResValid & ((iResTaken != iResPredTaken) | (iResTaken & iResPredTaken & (iResTarget != iResPredTarget))).
REQ-017 SHALL drive oFlush = mispredict combinationally, for exactly the cycle in which the resolve is presented.
REQ-018 SHALL select the next PC in priority order: (1) on mispredict, iResTarget if iResTaken, else iResPc+2, regardless of iStall; (2) on iStall, oPc held; (3) on oPredTaken, iBtbAddr; (4) otherwise oPc+2.
REQ-019 SHALL make the new PC visible on oPc one cycle after the selecting edge.
REQ-020 SHALL perform PC arithmetic modulo 2^16, so 16'hFFFE+2 gives 16'h0000.
REQ-021 SHALL, on iResValid, saturating-update BHT[idx(iResPc)]: increment if iResTaken (max 2'b11), decrement otherwise (min 2'b00); the write takes effect at the clock edge.
REQ-022 SHALL return the pre-update BHT value when a read and a write hit the same index in the same cycle.
REQ-023 SHALL drive oBtbWe = iResValid & iResTaken, oBtbWPc = iResPc and oBtbWAddr = iResTarget, all combinational.
REQ-024 SHALL increment oBrCount on every iResValid and oMissCount on every mispredict, each saturating at 16'hFFFF.

Reset
REQ-025 SHALL, while iRstN=0 at an edge, set oPc=RESET_PC, every BHT counter to 2'b01 (weakly not-taken), and oBrCount=oMissCount=0.
REQ-026 SHALL give reset priority over resolve, redirect and stall; a resolve presented in a reset cycle is discarded, and the BHT and counters are not updated.
REQ-027 SHALL, out of reset, output oPredTaken=0 on cold counters whatever iBtbHit, and oFlush, oBtbWe and oPredTaken follow their equations with no registered state.

Structure
REQ-028 SHALL place the bht_ctr typedef (2-bit) and the constant BHT_WEAKLY_NT=2'b01 in lc3b_types, alongside lc3b_word.
REQ-029 SHALL implement the counter array as one sub-module, bht_table, with async read, sync write and sync active-low reset; the PC mux, flush logic and statistics stay in br_next_pc.

Verification
REQ-030 SHALL cover: reset with RESET_PC=16'h3000 and no hits -> oPc steps 3000, 3002, 3004; counters read 0.
REQ-031 SHALL cover: iBtbHit=1, iBtbAddr=16'h4000 at oPc=16'h3004 with cold BHT -> oPredTaken=0, next oPc=3006; after two taken resolves of 3004, the same hit -> next oPc=4000.
REQ-032 SHALL cover: resolve Pc=3010, Taken=1, Target=5000, PredTaken=0 with iStall=1 -> oFlush=1 that cycle, oBtbWe=1, next oPc=5000, oMissCount=1.
REQ-033 SHALL cover: resolve Pc=3010, Taken=0, PredTaken=1 -> next oPc=3012, and the BHT counter steps 11->10.
REQ-034 SHALL cover: 70000 resolves -> oBrCount=FFFF (saturated); oPc=FFFE unstalled with no hit -> next oPc=0000.
REQ-035 SHALL cover: iRstN=0 with a simultaneous mispredicting resolve -> oPc=RESET_PC, BHT unchanged from the reset value 01, counters 0.

Source files
------------

// File: rtl/lc3b_types.sv
// lc3b_types: shared types for the LC-3b fetch front end.
//   lc3b_word     : 16-bit machine word / address.
//   bht_ctr       : 2-bit saturating branch-history counter.
//   BHT_WEAKLY_NT : counter value loaded at reset (weakly not-taken).
//   bht_sat_update: one saturating step of a counter toward the branch outcome.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  bht_ctr;

  localparam bht_ctr BHT_WEAKLY_NT = 2'b01;

  // Step toward taken (max 2'b11) or not-taken (min 2'b00).
  function automatic bht_ctr bht_sat_update(input bht_ctr ctr, input logic taken);
    bht_ctr res;
    res = ctr;
    if (taken) begin
      if (ctr != 2'b11) res = ctr + 2'b01;
    end else begin
      if (ctr != 2'b00) res = ctr - 2'b01;
    end
    return res;
  endfunction

endpackage

// File: rtl/br_next_pc_bht_table.sv
// bht_table: array of 2-bit saturating branch-history counters.
//   iClk    : clock, all writes on its rising edge.
//   iRstN   : synchronous active-low reset, loads every counter with BHT_WEAKLY_NT.
//   iRdIdx  : asynchronous read index; oRdCtr is the counter at that index.
//   iWe     : update enable; iWrIdx selects the counter, iTaken the direction.
// The read is combinational off the stored array, so a read and write to the
// same index in one cycle returns the value from before the write.
module bht_table
  import lc3b_types::*;
#(
  parameter int ENTRIES = 64
) (
  input  logic                       iClk,
  input  logic                       iRstN,
  input  logic [$clog2(ENTRIES)-1:0] iRdIdx,
  output bht_ctr                     oRdCtr,
  input  logic                       iWe,
  input  logic [$clog2(ENTRIES)-1:0] iWrIdx,
  input  logic                       iTaken
);

  bht_ctr ctr_q [ENTRIES];
  bht_ctr wr_ctr_d;

  always_comb begin
    wr_ctr_d = bht_sat_update(ctr_q[iWrIdx], iTaken);
  end

  assign oRdCtr = ctr_q[iRdIdx];

  always_ff @(posedge iClk) begin
    if (!iRstN) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= BHT_WEAKLY_NT;
      end
    end else if (iWe) begin
      ctr_q[iWrIdx] <= wr_ctr_d;
    end
  end

endmodule

// File: rtl/br_next_pc.sv
// br_next_pc: LC-3b fetch PC generator with BTB-assisted bimodal prediction.
//   iClk, iRstN     : clock and synchronous active-low reset.
//   iStall          : hold the fetch PC (a mispredict redirect still wins).
//   iBtbHit/iBtbAddr: BTB lookup result for the current oPc.
//   iRes*           : outcome of one resolved branch plus the prediction it carried.
//   oPc             : current fetch PC.
//   oPredTaken/oPredTarget : prediction for oPc (combinational).
//   oFlush          : mispredict pulse for the cycle the resolve is presented.
//   oBtbWe/oBtbWPc/oBtbWAddr : BTB write request for taken branches.
//   oBrCount/oMissCount      : saturating resolve / mispredict counters.
module br_next_pc
  import lc3b_types::*;
#(
  parameter int       BHT_ENTRIES = 64,
  parameter lc3b_word RESET_PC    = 16'h0000
) (
  input  logic     iClk,
  input  logic     iRstN,
  input  logic     iStall,
  input  logic     iBtbHit,
  input  lc3b_word iBtbAddr,
  input  logic     iResValid,
  input  lc3b_word iResPc,
  input  logic     iResTaken,
  input  lc3b_word iResTarget,
  input  logic     iResPredTaken,
  input  lc3b_word iResPredTarget,
  output lc3b_word oPc,
  output logic     oPredTaken,
  output lc3b_word oPredTarget,
  output logic     oFlush,
  output logic     oBtbWe,
  output lc3b_word oBtbWPc,
  output lc3b_word oBtbWAddr,
  output logic [15:0] oBrCount,
  output logic [15:0] oMissCount
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  lc3b_word    pc_q, pc_d;
  logic [15:0] br_cnt_q, br_cnt_d;
  logic [15:0] miss_cnt_q, miss_cnt_d;
  logic        mispredict;
  bht_ctr      rd_ctr;
  logic [IDX_W-1:0] rd_idx, wr_idx;

  // Bit 0 is always zero for word-aligned PCs, so it is skipped.
  assign rd_idx = pc_q[IDX_W:1];
  assign wr_idx = iResPc[IDX_W:1];

  bht_table #(
    .ENTRIES(BHT_ENTRIES)
  ) u_bht (
    .iClk  (iClk),
    .iRstN (iRstN),
    .iRdIdx(rd_idx),
    .oRdCtr(rd_ctr),
    .iWe   (iResValid),
    .iWrIdx(wr_idx),
    .iTaken(iResTaken)
  );

  assign oPredTaken  = iBtbHit & rd_ctr[1];
  assign oPredTarget = iBtbAddr;

  // Direction wrong, or both taken but to different targets.
  assign mispredict = iResValid &
                      ((iResTaken != iResPredTaken) |
                       (iResTaken & iResPredTaken & (iResTarget != iResPredTarget)));

  assign oFlush    = mispredict;
  assign oBtbWe    = iResValid & iResTaken;
  assign oBtbWPc   = iResPc;
  assign oBtbWAddr = iResTarget;

  always_comb begin
    pc_d = pc_q + 16'd2;
    if (mispredict) begin
      pc_d = iResTaken ? iResTarget : (iResPc + 16'd2);
    end else if (iStall) begin
      pc_d = pc_q;
    end else if (oPredTaken) begin
      pc_d = iBtbAddr;
    end
  end

  always_comb begin
    br_cnt_d   = br_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (iResValid && (br_cnt_q != 16'hFFFF)) br_cnt_d = br_cnt_q + 16'd1;
    if (mispredict && (miss_cnt_q != 16'hFFFF)) miss_cnt_d = miss_cnt_q + 16'd1;
  end

  always_ff @(posedge iClk) begin
    if (!iRstN) begin
      pc_q       <= RESET_PC;
      br_cnt_q   <= 16'd0;
      miss_cnt_q <= 16'd0;
    end else begin
      pc_q       <= pc_d;
      br_cnt_q   <= br_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign oPc        = pc_q;
  assign oBrCount   = br_cnt_q;
  assign oMissCount = miss_cnt_q;

endmodule

// File: tb/tb_br_next_pc.sv
module tb_br_next_pc;
  import lc3b_types::*;

  logic        iClk = 1'b0;
  logic        iRstN = 1'b0;
  logic        iStall = 1'b0;
  logic        iBtbHit = 1'b0;
  lc3b_word    iBtbAddr = 16'h0;
  logic        iResValid = 1'b0;
  lc3b_word    iResPc = 16'h0;
  logic        iResTaken = 1'b0;
  lc3b_word    iResTarget = 16'h0;
  logic        iResPredTaken = 1'b0;
  lc3b_word    iResPredTarget = 16'h0;
  lc3b_word    oPc;
  logic        oPredTaken;
  lc3b_word    oPredTarget;
  logic        oFlush;
  logic        oBtbWe;
  lc3b_word    oBtbWPc;
  lc3b_word    oBtbWAddr;
  logic [15:0] oBrCount;
  logic [15:0] oMissCount;

  int n_checks = 0;
  int n_fail = 0;

  br_next_pc #(.BHT_ENTRIES(64), .RESET_PC(16'h3000)) dut (
    .iClk(iClk), .iRstN(iRstN), .iStall(iStall),
    .iBtbHit(iBtbHit), .iBtbAddr(iBtbAddr),
    .iResValid(iResValid), .iResPc(iResPc), .iResTaken(iResTaken),
    .iResTarget(iResTarget), .iResPredTaken(iResPredTaken),
    .iResPredTarget(iResPredTarget),
    .oPc(oPc), .oPredTaken(oPredTaken), .oPredTarget(oPredTarget),
    .oFlush(oFlush), .oBtbWe(oBtbWe), .oBtbWPc(oBtbWPc), .oBtbWAddr(oBtbWAddr),
    .oBrCount(oBrCount), .oMissCount(oMissCount)
  );

  always #5 iClk = ~iClk;

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic clear_res();
    iResValid = 0; iResPc = 0; iResTaken = 0; iResTarget = 0;
    iResPredTaken = 0; iResPredTarget = 0;
  endtask

  task automatic set_res(input lc3b_word pc, input logic tk, input lc3b_word tgt,
                         input logic ptk, input lc3b_word ptgt);
    iResValid = 1; iResPc = pc; iResTaken = tk; iResTarget = tgt;
    iResPredTaken = ptk; iResPredTarget = ptgt;
  endtask

  task automatic do_reset();
    iRstN = 0; iStall = 0; iBtbHit = 0; iBtbAddr = 0;
    clear_res();
    tick();
    tick();
    iRstN = 1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (oPc !== 16'h3000) begin n_fail++; $display("FAIL reset_pc: got %h want %h", oPc, 16'h3000); end
    n_checks++; if (oBrCount !== 16'h0) begin n_fail++; $display("FAIL reset_brcnt: got %h want 0", oBrCount); end
    n_checks++; if (oMissCount !== 16'h0) begin n_fail++; $display("FAIL reset_misscnt: got %h want 0", oMissCount); end
    iBtbHit = 1; iBtbAddr = 16'h4000;
    #1;
    n_checks++; if (oPredTaken !== 1'b0) begin n_fail++; $display("FAIL cold_pred: got %b want 0", oPredTaken); end
    n_checks++; if (oFlush !== 1'b0 || oBtbWe !== 1'b0) begin n_fail++; $display("FAIL idle_flush_we: got %b%b want 00", oFlush, oBtbWe); end
    iBtbHit = 0; iBtbAddr = 0;
    tick();
    n_checks++; if (oPc !== 16'h3002) begin n_fail++; $display("FAIL step1_pc: got %h want %h", oPc, 16'h3002); end
    tick();
    n_checks++; if (oPc !== 16'h3004) begin n_fail++; $display("FAIL step2_pc: got %h want %h", oPc, 16'h3004); end
  endtask

  task automatic test_btb_pred();
    // oPc = 3004, BHT cold
    iBtbHit = 1; iBtbAddr = 16'h4000;
    #1;
    n_checks++; if (oPredTaken !== 1'b0) begin n_fail++; $display("FAIL hit_cold_pred: got %b want 0", oPredTaken); end
    n_checks++; if (oPredTarget !== 16'h4000) begin n_fail++; $display("FAIL pred_target: got %h want %h", oPredTarget, 16'h4000); end
    tick();
    n_checks++; if (oPc !== 16'h3006) begin n_fail++; $display("FAIL hit_cold_next: got %h want %h", oPc, 16'h3006); end
    // two correctly-predicted taken resolves of 3004 while stalled
    iBtbHit = 0; iBtbAddr = 0; iStall = 1;
    set_res(16'h3004, 1, 16'h4000, 1, 16'h4000);
    #1;
    n_checks++; if (oFlush !== 1'b0) begin n_fail++; $display("FAIL correct_no_flush: got %b want 0", oFlush); end
    n_checks++; if (oBtbWe !== 1'b1 || oBtbWPc !== 16'h3004 || oBtbWAddr !== 16'h4000) begin
      n_fail++; $display("FAIL btb_write: got we=%b pc=%h addr=%h want 1 3004 4000", oBtbWe, oBtbWPc, oBtbWAddr); end
    tick();
    tick();
    n_checks++; if (oPc !== 16'h3006) begin n_fail++; $display("FAIL stall_hold: got %h want %h", oPc, 16'h3006); end
    // redirect back to 3004 via a not-taken mispredict of 3002
    iStall = 0;
    set_res(16'h3002, 0, 16'h0000, 1, 16'h5555);
    #1;
    n_checks++; if (oFlush !== 1'b1 || oBtbWe !== 1'b0) begin n_fail++; $display("FAIL nt_miss_flush_we: got %b%b want 10", oFlush, oBtbWe); end
    tick();
    clear_res();
    n_checks++; if (oPc !== 16'h3004) begin n_fail++; $display("FAIL nt_redirect: got %h want %h", oPc, 16'h3004); end
    iBtbHit = 1; iBtbAddr = 16'h4000;
    #1;
    n_checks++; if (oPredTaken !== 1'b1) begin n_fail++; $display("FAIL warm_pred: got %b want 1", oPredTaken); end
    tick();
    iBtbHit = 0; iBtbAddr = 0;
    n_checks++; if (oPc !== 16'h4000) begin n_fail++; $display("FAIL warm_next: got %h want %h", oPc, 16'h4000); end
    n_checks++; if (oBrCount !== 16'd3 || oMissCount !== 16'd1) begin
      n_fail++; $display("FAIL counts_a: got br=%0d miss=%0d want 3 1", oBrCount, oMissCount); end
  endtask

  task automatic test_mispredict_stall();
    do_reset();
    iStall = 1;
    set_res(16'h3010, 1, 16'h5000, 0, 16'h0000);
    #1;
    n_checks++; if (oFlush !== 1'b1) begin n_fail++; $display("FAIL miss_flush: got %b want 1", oFlush); end
    n_checks++; if (oBtbWe !== 1'b1 || oBtbWPc !== 16'h3010 || oBtbWAddr !== 16'h5000) begin
      n_fail++; $display("FAIL miss_btb: got we=%b pc=%h addr=%h want 1 3010 5000", oBtbWe, oBtbWPc, oBtbWAddr); end
    tick();
    clear_res();
    #1;
    n_checks++; if (oPc !== 16'h5000) begin n_fail++; $display("FAIL miss_redirect: got %h want %h", oPc, 16'h5000); end
    n_checks++; if (oMissCount !== 16'd1 || oBrCount !== 16'd1) begin
      n_fail++; $display("FAIL miss_counts: got br=%0d miss=%0d want 1 1", oBrCount, oMissCount); end
    n_checks++; if (oFlush !== 1'b0) begin n_fail++; $display("FAIL flush_one_cycle: got %b want 0", oFlush); end
    iStall = 0;
  endtask

  task automatic test_not_taken();
    // BHT[3010] is 10 after the previous task; get oPc to 3010
    set_res(16'h300E, 0, 16'h0000, 1, 16'h1234);
    tick();
    n_checks++; if (oPc !== 16'h3010) begin n_fail++; $display("FAIL nt_to_3010: got %h want %h", oPc, 16'h3010); end
    iStall = 1;
    set_res(16'h3010, 1, 16'h5000, 1, 16'h5000);
    tick();
    clear_res();
    iBtbHit = 1; iBtbAddr = 16'h5000;
    #1;
    n_checks++; if (oPredTaken !== 1'b1) begin n_fail++; $display("FAIL strong_pred: got %b want 1", oPredTaken); end
    iStall = 0; iBtbHit = 0;
    set_res(16'h3010, 0, 16'h0000, 1, 16'h5000);
    #1;
    n_checks++; if (oFlush !== 1'b1) begin n_fail++; $display("FAIL nt_flush: got %b want 1", oFlush); end
    tick();
    n_checks++; if (oPc !== 16'h3012) begin n_fail++; $display("FAIL nt_next: got %h want %h", oPc, 16'h3012); end
    set_res(16'h300E, 0, 16'h0000, 1, 16'h1234);
    tick();
    clear_res();
    iBtbHit = 1; iStall = 1;
    #1;
    n_checks++; if (oPc !== 16'h3010 || oPredTaken !== 1'b1) begin
      n_fail++; $display("FAIL ctr_10: got pc=%h pred=%b want 3010 1", oPc, oPredTaken); end
    // same-cycle read and write: read sees the pre-update counter
    set_res(16'h3010, 0, 16'h0000, 0, 16'h0000);
    #1;
    n_checks++; if (oPredTaken !== 1'b1 || oFlush !== 1'b0) begin
      n_fail++; $display("FAIL rd_before_wr: got pred=%b flush=%b want 1 0", oPredTaken, oFlush); end
    tick();
    clear_res();
    #1;
    n_checks++; if (oPredTaken !== 1'b0) begin n_fail++; $display("FAIL ctr_01: got %b want 0", oPredTaken); end
    iBtbHit = 0; iStall = 0;
  endtask

  task automatic test_saturation();
    do_reset();
    iStall = 1;
    set_res(16'h0000, 0, 16'h0000, 0, 16'h0000);
    for (int i = 0; i < 65534; i++) tick();
    n_checks++; if (oBrCount !== 16'hFFFE) begin n_fail++; $display("FAIL brcnt_fffe: got %h want fffe", oBrCount); end
    for (int i = 0; i < 70000 - 65534; i++) tick();
    n_checks++; if (oBrCount !== 16'hFFFF) begin n_fail++; $display("FAIL brcnt_sat: got %h want ffff", oBrCount); end
    n_checks++; if (oMissCount !== 16'h0) begin n_fail++; $display("FAIL misscnt_zero: got %h want 0", oMissCount); end
    set_res(16'h1000, 1, 16'hFFFE, 0, 16'h0000);
    tick();
    clear_res();
    iStall = 0;
    n_checks++; if (oPc !== 16'hFFFE || oBrCount !== 16'hFFFF) begin
      n_fail++; $display("FAIL to_fffe: got pc=%h br=%h want fffe ffff", oPc, oBrCount); end
    tick();
    n_checks++; if (oPc !== 16'h0000) begin n_fail++; $display("FAIL pc_wrap: got %h want 0000", oPc); end
  endtask

  task automatic test_reset_priority();
    iRstN = 0; iStall = 0;
    set_res(16'h3010, 1, 16'h5000, 0, 16'h0000);
    tick();
    tick();
    clear_res();
    iRstN = 1;
    n_checks++; if (oPc !== 16'h3000) begin n_fail++; $display("FAIL rstprio_pc: got %h want 3000", oPc); end
    n_checks++; if (oBrCount !== 16'h0 || oMissCount !== 16'h0) begin
      n_fail++; $display("FAIL rstprio_counts: got br=%h miss=%h want 0 0", oBrCount, oMissCount); end
    // reach 3010 and confirm its counter is 01 (not taken, one step from taken)
    set_res(16'h300E, 0, 16'h0000, 1, 16'h1234);
    tick();
    clear_res();
    iBtbHit = 1; iBtbAddr = 16'h5000; iStall = 1;
    #1;
    n_checks++; if (oPc !== 16'h3010 || oPredTaken !== 1'b0) begin
      n_fail++; $display("FAIL rstprio_ctr_nt: got pc=%h pred=%b want 3010 0", oPc, oPredTaken); end
    set_res(16'h3010, 1, 16'h5000, 1, 16'h5000);
    tick();
    clear_res();
    #1;
    n_checks++; if (oPredTaken !== 1'b1) begin n_fail++; $display("FAIL rstprio_ctr_01: got %b want 1", oPredTaken); end
    iBtbHit = 0; iStall = 0;
  endtask

  initial begin
    test_reset();
    test_btb_pred();
    test_mispredict_stall();
    test_not_taken();
    test_saturation();
    test_reset_priority();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
